// File: rtl/conv_fprop2_acc_sat.sv
// Accumulate/requantize stage behind the conv_fprop2 multiplier array.
// Sums KLEN products plus bias, rounds, shifts, clamps, single result register.
module conv_fprop2_acc_sat #(
  parameter int PROD_WIDTH = 10,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int KLEN       = 9,
  parameter int SHIFT      = 2,
  parameter int RELU       = 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic signed [PROD_WIDTH-1:0]  prod_dat,
  input  logic                          prod_vld,
  output logic                          prod_rdy,
  input  logic signed [ACC_WIDTH-1:0]   bias_dat,
  output logic signed [OUT_WIDTH-1:0]   out_dat,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [$clog2(KLEN+1)-1:0]     tap_cnt,
  output logic                          acc_ovf
);

  localparam int TW  = $clog2(KLEN + 1);
  localparam int AW1 = ACC_WIDTH + 1;
  localparam int RNDI = (2 ** SHIFT) / 2;

  localparam logic [TW-1:0] LAST = TW'(KLEN - 1);
  localparam logic signed [AW1-1:0] RND = AW1'(RNDI);
  localparam logic [ACC_WIDTH-1:0] AMAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AMIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [AW1-1:0] OMAX =
    {{(AW1-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW1-1:0] OMIN =
    {{(AW1-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic [TW-1:0]               tap_q, tap_d;
  logic                        ovf_q, ovf_d;
  logic                        vld_q, vld_d;
  logic signed [OUT_WIDTH-1:0] dat_q, dat_d;

  logic signed [AW1-1:0]       base_w;
  logic signed [AW1-1:0]       pext_w;
  logic signed [AW1-1:0]       sum_w;
  logic                        sat_w;
  logic [ACC_WIDTH-1:0]        clmp_w;
  logic signed [AW1-1:0]       rnd_w;
  logic signed [AW1-1:0]       shr_w;
  logic signed [OUT_WIDTH-1:0] res_w;
  logic                        acc_ev;
  logic                        last_w;

  assign prod_rdy = !vld_q || out_rdy;
  assign acc_ev   = prod_vld && prod_rdy;
  assign last_w   = (tap_q == LAST);

  always_comb begin
    base_w = (tap_q == '0) ? {bias_dat[ACC_WIDTH-1], bias_dat}
                           : {acc_q[ACC_WIDTH-1], acc_q};
    pext_w = {{(AW1-PROD_WIDTH){prod_dat[PROD_WIDTH-1]}}, prod_dat};
    sum_w  = base_w + pext_w;
    sat_w  = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
    clmp_w = sum_w[ACC_WIDTH-1:0];
    if (sat_w) clmp_w = sum_w[ACC_WIDTH] ? AMIN : AMAX;
    // one guard bit so rounding the max accumulator cannot wrap
    rnd_w  = {clmp_w[ACC_WIDTH-1], clmp_w} + RND;
    shr_w  = rnd_w >>> SHIFT;
    if (RELU != 0 && shr_w[AW1-1]) shr_w = '0;
    res_w  = shr_w[OUT_WIDTH-1:0];
    if (shr_w > OMAX) res_w = OMAX[OUT_WIDTH-1:0];
    else if (shr_w < OMIN) res_w = OMIN[OUT_WIDTH-1:0];
  end

  always_comb begin
    acc_d = acc_q;
    tap_d = tap_q;
    ovf_d = ovf_q;
    vld_d = vld_q;
    dat_d = dat_q;
    if (acc_ev) begin
      acc_d = clmp_w;
      ovf_d = ovf_q || sat_w;
      tap_d = last_w ? '0 : tap_q + TW'(1);
    end
    if (acc_ev && last_w) begin
      vld_d = 1'b1;
      dat_d = res_w;
    end else if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q <= '0;
      tap_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      acc_q <= acc_d;
      tap_q <= tap_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_dat = dat_q;
  assign out_vld = vld_q;
  assign tap_cnt = tap_q;
  assign acc_ovf = ovf_q;

endmodule

// File: doc/conv_fprop2_acc_sat.md
# conv_fprop2_acc_sat

Downstream accumulate/requantize stage for the conv_fprop2 multiplier.
- Consumes the stream of 10-bit signed products, one per cycle, and sums KLEN products plus a per-output bias.
- Rounds, shifts, optionally applies ReLU and saturates each sum to an OUT_WIDTH signed activation.
- Presents each activation on a valid/ready output with a single result register.
- Sits between the multiplier array and the output-activation writer.

## Interface
- PROD_WIDTH, 10, signed product width (matches multiplier output)
- ACC_WIDTH, 20, signed accumulator and bias width
- OUT_WIDTH, 8, signed result width
- KLEN, 9, products per output (≥1)
- SHIFT, 2, requantization right shift (≥0)
- RELU, 1, 1 = clamp negative results to 0

- ap_clk  in  1  clock; all state updates on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- prod_dat  in  PROD_WIDTH  signed product
- prod_vld  in  1  product valid
- prod_rdy  out  1  product accepted when prod_vld & prod_rdy
- bias_dat  in  ACC_WIDTH  signed bias, sampled only on first product of a group
- out_dat  out  OUT_WIDTH  signed result
- out_vld  out  1  result valid
- out_rdy  in  1  result consumed when out_vld & out_rdy
- tap_cnt  out  ceil(log2(KLEN+1))  products accepted in current group
- acc_ovf  out  1  sticky accumulator-saturation flag

## Operation
- Reset values: prod_rdy follows its equation; out_vld=0, out_dat=0, tap_cnt=0, acc=0, acc_ovf=0.
- prod_rdy = !out_vld | out_rdy. This is combinational; no bubble when the output drains in the same cycle.
- On product accept:
  - sum = (tap_cnt==0 ? bias_dat : acc) + sext(prod_dat), computed at ACC_WIDTH+1 bits.
  - sum saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. On clamp, acc_ovf<=1. acc_ovf clears only on reset.
  - acc <= clamped sum.
  - tap_cnt increments. On reaching KLEN it wraps to 0 (group complete).
- On group completion, the result register loads from the clamped sum of that same cycle:
  - r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. This is arithmetic shift, round-half-up. Do not saturate before rounding.
  - If RELU=1 and r<0, then r=0.
  - out_dat = r clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - out_vld<=1.
- Output accept without a new completion in the same cycle: out_vld<=0. out_dat holds its last value.
- Simultaneous output accept and group completion: out_vld stays 1 and out_dat takes the new result.
- While out_vld=1 and out_rdy=0:
  - prod_rdy=0.
  - out_dat, tap_cnt and acc frozen.
- prod_vld=0 gaps mid-group: no state change.
- Reset mid-group or with a pending result:
  - Partial sum is discarded. Pending result is dropped.
  - All outputs return to their reset values the cycle after ap_rst is sampled high.
  - The first product accepted after reset starts a new group with bias.

## Timing
- Latency: out_vld rises 1 cycle after the edge that accepts the KLEN-th product.
- Throughput: 1 product/cycle sustained when out_rdy=1. One result every KLEN cycles, no stall cycles.
- No combinational path from prod_vld or prod_dat to any output. prod_rdy depends combinationally on out_rdy only.
- out_dat and out_vld are registered. out_dat is stable while out_vld=1 and out_rdy=0.

## Test plan
Default parameters unless noted.
- Basic: bias=0, nine products of 10, out_rdy=1 -> out_dat=23 (90+2>>2), out_vld high 1 cycle after 9th accept, acc_ovf=0.
- Negative/ReLU: bias=0, nine products of -512:
  - RELU=1 -> out_dat=0.
  - RELU=0 -> (-4608+2)>>>2=-1152 -> out_dat=-128.
- Output saturation: bias=1000, nine products of 511 -> 5599 -> 1400 -> out_dat=127, acc_ovf=0.
- Accumulator saturation: bias=524287, products of +1 -> acc held at 524287, acc_ovf=1 and stays 1 through later groups until ap_rst.
- Backpressure:
  - Stimulus: result pending, out_rdy=0 for 5 cycles, prod_vld=1.
  - Response: prod_rdy=0, out_dat stable, tap_cnt=0. When out_rdy=1, next group proceeds with no lost or duplicated products.
  - Stimulus: 18 back-to-back products with out_rdy=1.
  - Response: prod_rdy never drops and exactly two results appear.
- Reset mid-group: ap_rst high for 1 cycle after 4 products -> tap_cnt=0, out_vld=0. Next 9 products of 4 with bias 0 -> out_dat=9 ((36+2)>>2).
